window_streamer: RTL
====================

WINDOW_STREAMER -- requirements
Module: window_streamer

Interface
REQ-001 Parameter IMG_W, default 16: image width in pixels, minimum 3.
REQ-002 Parameter IMG_H, default 16: image height in pixels, minimum 3.
REQ-003 Parameter PIX_W, default 8: pixel width in bits.
REQ-004 Port clk, input, 1 bit: single clock; all state SHALL update on its rising edge.
REQ-005 Port reset, input, 1 bit: asynchronous, active-high reset.
REQ-006 Port enb, input, 1 bit: global enable; when low the block SHALL stall.
REQ-007 Port pix_in, input, PIX_W bits: raster-order pixel stream into the block.
REQ-008 Port pix_valid, input, 1 bit: pix_in is valid this cycle.
REQ-009 Port win_out, output, 9*PIX_W bits: 3x3 window sent to the smoothing filter.
REQ-010 Port win_valid, output, 1 bit: win_out is valid; one-cycle pulse per window.
REQ-011 Port frame_done, output, 1 bit: one-cycle pulse after the last pixel of a frame.

Function
REQ-012 A pixel SHALL be accepted only in a cycle where enb=1 and pix_valid=1.
REQ-013 Column counter: 0..IMG_W-1, +1 per accepted pixel; wraps to 0 and increments the row counter.
REQ-014 Row counter: 0..IMG_H-1; on acceptance at (IMG_H-1, IMG_W-1), both counters SHALL return to 0.
REQ-015 Two line buffers, each IMG_W deep, SHALL hold rows r-1 and r-2; each shifts once per accepted pixel.
REQ-016 Window: rows r-2..r by columns c-2..c. Packing: slot k = 3*rowoffset + coloffset (0 = top-left, 8 = newest pixel) at bits [k*PIX_W +: PIX_W].
REQ-017 win_valid SHALL assert exactly one cycle after accepting a pixel at row>=2 and col>=2; win_out is registered and held until the next window.
REQ-018 Windows per frame: exactly (IMG_W-2)*(IMG_H-2); none straddle a row wrap.
REQ-019 frame_done SHALL assert one cycle after accepting the last frame pixel, coinciding with the final win_valid.
REQ-020 FSM states:
- IDLE: no pixel accepted this frame.
- FILL: row<2 or col<2.
- STREAM: window-producing position.
- Transitions: IDLE->FILL on first acceptance; FILL<->STREAM by position; any->IDLE on frame end.
REQ-021 With enb=0: counters, buffers, FSM and win_out hold; win_valid and frame_done SHALL be 0 in the following cycle.
REQ-022 pix_valid=0 with enb=1 SHALL behave like enb=0 for acceptance; gaps of any length are legal.
REQ-023 A new frame's first pixel may be accepted in the cycle immediately after the previous frame's last pixel.
REQ-024 Line buffer contents need not be cleared between frames; windows SHALL never use pixels from a previous frame.

Reset
REQ-025 While reset=1, the block SHALL asynchronously set:
- counters to 0, FSM to IDLE
- win_out to 0, win_valid to 0, frame_done to 0.
REQ-026 Reset mid-frame SHALL discard the partial frame; the next accepted pixel is (0,0) of a new frame.

Structure
REQ-027 The shared yoda_ced package SHALL hold PIX_W, IMG_W and IMG_H defaults plus the FSM state encodings; the smoothing filter SHALL use the same package.
REQ-028 One sub-module, line_buffer (IMG_W x PIX_W shift register with enable), SHALL be instantiated twice.

Verification
REQ-029 Ramp frame, IMG_W=4, IMG_H=4, pixels 0..15 back-to-back -> 4 windows; first window one cycle after pixel 10 = {0,1,2,4,5,6,8,9,10}; last = {5,6,7,9,10,11,13,14,15} with frame_done.
REQ-030 Same ramp with enb low 3 cycles after pixel 6 -> identical windows delayed by 3 cycles; no win_valid during the stall.
REQ-031 Random pix_valid gaps over a 16x16 frame -> exactly 196 win_valid pulses; contents match the reference model.
REQ-032 Reset asserted after pixel 9 of a 4x4 frame, then a fresh ramp 100..115 -> first window {100,101,102,104,105,106,108,109,110}.
REQ-033 Two back-to-back 4x4 frames (0..15, then 16..31) -> 8 windows, two frame_done pulses; second frame's first window = {16,17,18,20,21,22,24,25,26}.

Source files
------------

// File: rtl/yoda_ced_pkg.sv
// Shared definitions for the edge-detect pipeline: default image geometry
// and the window streamer's state encoding, also used by the smoothing filter.
package yoda_ced;

  localparam int PIX_W_DEF = 8;
  localparam int IMG_W_DEF = 16;
  localparam int IMG_H_DEF = 16;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FILL   = 2'd1,
    ST_STREAM = 2'd2
  } ced_state_e;

endpackage

// File: rtl/line_buffer.sv
// One image row of delay: a DEPTH-deep pixel shift register that advances
// only when enabled. The output is the pixel from DEPTH shifts ago.
module line_buffer
  import yoda_ced::*;
#(
  parameter int DEPTH = IMG_W_DEF,
  parameter int PIX_W = PIX_W_DEF
) (
  input  logic             clk,
  input  logic             i_en,
  input  logic [PIX_W-1:0] i_din,
  output logic [PIX_W-1:0] o_dout
);

  logic [PIX_W-1:0] r_mem [DEPTH];

  // NOTE: storage has no reset; rows are always refilled before any window reads them.
  always_ff @(posedge clk) begin
    if (i_en) begin
      r_mem[0] <= i_din;
      for (int i = 1; i < DEPTH; i++) r_mem[i] <= r_mem[i-1];
    end
  end

  assign o_dout = r_mem[DEPTH-1];

endmodule

// File: rtl/window_streamer.sv
// Turns a raster pixel stream into registered 3x3 windows for the smoothing
// filter, one window per pixel accepted at row>=2, col>=2.
module window_streamer
  import yoda_ced::*;
#(
  parameter int IMG_W = IMG_W_DEF,
  parameter int IMG_H = IMG_H_DEF,
  parameter int PIX_W = PIX_W_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enb,
  input  logic [PIX_W-1:0]   pix_in,
  input  logic               pix_valid,
  output logic [9*PIX_W-1:0] win_out,
  output logic               win_valid,
  output logic               frame_done
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);

  logic [CW-1:0]        r_col;
  logic [RW-1:0]        r_row;
  ced_state_e           r_state, w_state_nxt;
  logic [3*PIX_W-1:0]   r_col_m2, r_col_m1;
  logic [3*PIX_W-1:0]   w_col_new;
  logic [PIX_W-1:0]     w_lb1_out, w_lb2_out;
  logic [9*PIX_W-1:0]   w_win;
  logic                 w_accept, w_col_last, w_frame_last, w_in_window;
  logic                 w_win_load, w_done_nxt;

  assign w_accept     = enb & pix_valid;
  assign w_col_last   = (r_col == CW'(IMG_W - 1));
  assign w_frame_last = w_col_last && (r_row == RW'(IMG_H - 1));
  assign w_in_window  = (r_row >= RW'(2)) && (r_col >= CW'(2));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_col <= '0;
      r_row <= '0;
    end else if (w_accept) begin
      // NOTE: non-blocking so every register samples pre-edge values of the others.
      if (w_col_last) begin
        r_col <= '0;
        r_row <= w_frame_last ? '0 : r_row + RW'(1);
      end else begin
        r_col <= r_col + CW'(1);
      end
    end
  end

  // lb1 holds row r-1, lb2 holds row r-2; both tap the same column as pix_in.
  line_buffer #(.DEPTH(IMG_W), .PIX_W(PIX_W)) u_lb1 (
    .clk(clk), .i_en(w_accept), .i_din(pix_in), .o_dout(w_lb1_out)
  );
  line_buffer #(.DEPTH(IMG_W), .PIX_W(PIX_W)) u_lb2 (
    .clk(clk), .i_en(w_accept), .i_din(w_lb1_out), .o_dout(w_lb2_out)
  );

  // Column word: [0] = row r-2, [1] = row r-1, [2] = current row.
  assign w_col_new = {pix_in, w_lb1_out, w_lb2_out};

  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_col_m2 <= r_col_m1;
      r_col_m1 <= w_col_new;
    end
  end

  always_comb begin
    w_win = '0;
    for (int i = 0; i < 3; i++) begin
      w_win[(3*i + 0)*PIX_W +: PIX_W] = r_col_m2[i*PIX_W +: PIX_W];
      w_win[(3*i + 1)*PIX_W +: PIX_W] = r_col_m1[i*PIX_W +: PIX_W];
      w_win[(3*i + 2)*PIX_W +: PIX_W] = w_col_new[i*PIX_W +: PIX_W];
    end
  end

  always_comb begin
    // NOTE: defaults first so no path leaves a signal unassigned (no latches).
    w_state_nxt = r_state;
    w_win_load  = 1'b0;
    w_done_nxt  = 1'b0;
    if (w_accept) begin
      w_win_load = w_in_window;
      w_done_nxt = w_frame_last;
      if (w_frame_last)     w_state_nxt = ST_IDLE;
      else if (w_in_window) w_state_nxt = ST_STREAM;
      else                  w_state_nxt = ST_FILL;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      win_out    <= '0;
      win_valid  <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      win_valid  <= w_win_load;
      frame_done <= w_done_nxt;
      if (w_win_load) win_out <= w_win;
    end
  end

endmodule
